// File: rtl/frame_bram_arbiter_pkg.sv
// Shared constants for the frame-buffer BRAM arbiter: BRAM geometry,
// requester numbering in the stereo path, and the lock FSM state type.
package frame_bram_arbiter_pkg;

  localparam int FB_ADDR_WIDTH  = 17;
  localparam int FB_DATA_WIDTH  = 16;
  localparam int FB_RAM_LATENCY = 2;
  localparam int FB_NUM_REQ     = 3;
  localparam int FB_MAX_BURST   = 8;

  localparam int REQ_CAM  = 0;
  localparam int REQ_DISP = 1;
  localparam int REQ_UART = 2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/frame_bram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of mask at or above start,
// wrapping around, returned as one-hot grant plus its index.
module frame_bram_arbiter_rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  // Walk from the farthest candidate back to start so the closest one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (mask[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_bram_arbiter.sv
// Shares one frame-buffer BRAM port between NUM_REQ requesters with per-beat
// round-robin, optional burst lock, registered RAM outputs and tagged read return.
module frame_bram_arbiter
  import frame_bram_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = FB_NUM_REQ,
  parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = FB_DATA_WIDTH,
  parameter int RAM_LATENCY = FB_RAM_LATENCY,
  parameter int MAX_BURST   = FB_MAX_BURST
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ-1:0]            req_we_in,
  input  logic [NUM_REQ-1:0]            req_lock_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out,
  output logic [ADDR_WIDTH-1:0]         ram_addr_out,
  output logic [DATA_WIDTH-1:0]         ram_din_out,
  output logic                          ram_we_out,
  output logic                          ram_en_out,
  input  logic [DATA_WIDTH-1:0]         ram_dout_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx_out
);

  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam int TAG_DEPTH = RAM_LATENCY + 1;

  lock_state_t      state, state_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_next;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] owner_mask;
  logic               others_valid;
  logic               hold;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;

  logic [TAG_DEPTH-1:0]            tag_valid;
  logic [TAG_DEPTH-1:0][IDX_W-1:0] tag_idx;

  frame_bram_arbiter_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .mask  (req_valid_in),
    .start (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The owner keeps the port unless it has used up its burst while someone waits.
  assign owner_mask   = NUM_REQ'(1) << owner;
  assign others_valid = |(req_valid_in & ~owner_mask);
  assign hold         = (state == LOCKED) && req_valid_in[owner] &&
                        !((burst_cnt == CNT_W'(MAX_BURST)) && others_valid);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    accept    = 1'b0;
    if (!rst_in) begin
      if (hold) begin
        grant[owner] = 1'b1;
        grant_idx    = owner;
        accept       = 1'b1;
      end else if (pick_any) begin
        grant     = pick_grant;
        grant_idx = pick_idx;
        accept    = 1'b1;
      end
    end
  end

  assign req_ready_out = grant;

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    burst_cnt_next = burst_cnt;
    rr_ptr_next    = rr_ptr;
    if (accept) begin
      rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (req_lock_in[grant_idx]) begin
        state_next = LOCKED;
        owner_next = grant_idx;
        if (hold) begin
          burst_cnt_next = (burst_cnt == CNT_W'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
        end else begin
          burst_cnt_next = CNT_W'(1);
        end
      end else begin
        state_next     = UNLOCKED;
        burst_cnt_next = '0;
      end
    end else if ((state == LOCKED) && !req_valid_in[owner]) begin
      state_next     = UNLOCKED;
      burst_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= UNLOCKED;
      owner         <= '0;
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      ram_en_out    <= 1'b0;
      ram_we_out    <= 1'b0;
      ram_addr_out  <= '0;
      ram_din_out   <= '0;
      grant_idx_out <= '0;
      tag_valid     <= '0;
      tag_idx       <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      rr_ptr     <= rr_ptr_next;
      burst_cnt  <= burst_cnt_next;
      ram_en_out <= accept;
      ram_we_out <= accept && req_we_in[grant_idx];
      if (accept) begin
        ram_addr_out  <= req_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din_out   <= req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        grant_idx_out <= grant_idx;
      end
      // Reads only; the tag reaches the last stage when the BRAM data does.
      tag_valid <= {tag_valid[TAG_DEPTH-2:0], accept && !req_we_in[grant_idx]};
      tag_idx   <= {tag_idx[TAG_DEPTH-2:0], grant_idx};
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    if (tag_valid[TAG_DEPTH-1]) begin
      rsp_valid_out[tag_idx[TAG_DEPTH-1]] = 1'b1;
    end
  end

  assign rsp_data_out = tag_valid[TAG_DEPTH-1] ? ram_dout_in : '0;

endmodule

// File: tb/tb_frame_bram_arbiter.sv
// Directed bench for frame_bram_arbiter with a read-first, two-cycle BRAM model.
module tb_frame_bram_arbiter;
  import frame_bram_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, ram_din, ram_dout;
  logic [AW-1:0]   ram_addr;
  logic            ram_we, ram_en;
  logic [1:0]      grant_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frame_bram_arbiter dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .req_we_in     (req_we),
    .req_lock_in   (req_lock),
    .req_addr_in   (req_addr),
    .req_data_in   (req_data),
    .rsp_valid_out (rsp_valid),
    .rsp_data_out  (rsp_data),
    .ram_addr_out  (ram_addr),
    .ram_din_out   (ram_din),
    .ram_we_out    (ram_we),
    .ram_en_out    (ram_en),
    .ram_dout_in   (ram_dout),
    .grant_idx_out (grant_idx)
  );

  // BRAM model: unwritten locations read as 16'hA000 + address.
  logic [DW-1:0] mem [int];
  logic [DW-1:0] rd1 = '0;
  logic [DW-1:0] rd2 = '0;

  function automatic logic [DW-1:0] mem_read(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'hA000 + DW'(a);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      rd1 <= mem_read(int'(ram_addr));
      if (ram_we) mem[int'(ram_addr)] = ram_din;
    end
    rd2 <= rd1;
  end

  assign ram_dout = rd2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input int a);
    req_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int            exp4 [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 4, 1, 1, 1, 1};
  int            b0;
  logic          done2;
  logic [N-1:0]  got;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);

    // 1: single write from the camera
    req_valid = 3'b001;
    req_we    = 3'b001;
    set_addr(REQ_CAM, 5);
    set_data(REQ_CAM, 16'hBEEF);
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("t1_ram_en", 32'(ram_en), 32'd1);
    check("t1_ram_we", 32'(ram_we), 32'd1);
    check("t1_ram_addr", 32'(ram_addr), 32'd5);
    check("t1_ram_din", 32'(ram_din), 32'hBEEF);
    check("t1_rsp", 32'(rsp_valid), 32'd0);
    check("t1_grant_idx", 32'(grant_idx), 32'd0);

    // 2: disparity reader reads it back three cycles later
    req_valid = 3'b010;
    req_we    = '0;
    set_addr(REQ_DISP, 5);
    #1;
    check("t2_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check("t2_ram_en", 32'(ram_en), 32'd1);
    check("t2_ram_we", 32'(ram_we), 32'd0);
    check("t2_ram_addr", 32'(ram_addr), 32'd5);
    check("t2_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    check("t2_rsp_t2", 32'(rsp_valid), 32'd0);
    tick();
    check("t2_rsp_valid", 32'(rsp_valid), 32'h2);
    check("t2_rsp_data", 32'(rsp_data), 32'hBEEF);
    tick();
    check("t2_rsp_after", 32'(rsp_valid), 32'd0);

    // 3: all three read continuously, pointer restarted by reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_addr(0, 20);
    set_addr(1, 21);
    set_addr(2, 22);
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 6) ? 3'b111 : 3'b000;
      #1;
      if (k < 6) check($sformatf("t3_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      if (k < 6) check($sformatf("t3_gidx_%0d", k), 32'(grant_idx), 32'(k % 3));
      if (k >= 2) begin
        check($sformatf("t3_rsp_%0d", k - 2), 32'(rsp_valid), 32'(1 << ((k - 2) % 3)));
        check($sformatf("t3_data_%0d", k - 2), 32'(rsp_data), 32'(16'hA014 + (k - 2) % 3));
      end else begin
        check($sformatf("t3_rsp_idle_%0d", k), 32'(rsp_valid), 32'd0);
      end
    end

    // 4: camera locks a 12-beat write burst while the UART waits to read
    req_we = 3'b001;
    set_addr(REQ_UART, 30);
    b0    = 0;
    done2 = 1'b0;
    for (int c = 0; c < 13; c++) begin
      req_valid = {!done2, 1'b0, (b0 < 12)};
      req_lock  = {2'b00, (b0 < 11)};
      set_addr(REQ_CAM, 100 + b0);
      set_data(REQ_CAM, 16'h4000 + DW'(b0));
      #1;
      check($sformatf("t4_ready_%0d", c), 32'(req_ready), 32'(exp4[c]));
      got = req_ready;
      tick();
      if (got[REQ_CAM]) b0++;
      if (got[REQ_UART]) done2 = 1'b1;
      check($sformatf("t4_rsp_%0d", c), 32'(rsp_valid), (c == 10) ? 32'h4 : 32'h0);
      if (c == 10) check("t4_rsp_data", 32'(rsp_data), 32'hA01E);
    end
    req_valid = '0;
    req_lock  = '0;

    // 5: lone locked burst saturates, then a newcomer gets the very next beat
    req_we   = 3'b001;
    req_lock = 3'b001;
    for (int c = 0; c < 12; c++) begin
      req_valid = 3'b001;
      set_addr(REQ_CAM, 200 + c);
      #1;
      check($sformatf("t5_ready_%0d", c), 32'(req_ready), 32'h1);
      tick();
    end
    req_valid = 3'b011;
    set_addr(REQ_DISP, 50);
    #1;
    check("t5_forced_rotate", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    req_lock  = '0;
    tick();
    tick();
    check("t5_rsp_valid", 32'(rsp_valid), 32'h2);
    check("t5_rsp_data", 32'(rsp_data), 32'hA032);

    // 6: reset right after two reads drops both responses
    req_we = '0;
    set_addr(0, 40);
    set_addr(1, 41);
    req_valid = 3'b001;
    #1;
    check("t6_ready_a", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b010;
    #1;
    check("t6_ready_b", 32'(req_ready), 32'h2);
    tick();
    rst       = 1'b1;
    req_valid = 3'b111;
    #1;
    check("t6_ready_in_rst", 32'(req_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("t6_ram_en_rst_%0d", c), 32'(ram_en), 32'd0);
      check($sformatf("t6_rsp_rst_%0d", c), 32'(rsp_valid), 32'd0);
    end
    rst       = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("t6_rsp_after_%0d", c), 32'(rsp_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
